// File: rtl/capture_ram_pkg.sv
// Shared types and default parameters for the capture RAM.
package capture_ram_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_POST = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/capture_ram_mem.sv
// Simple dual-port sample store: one write port, one registered read-first read port.
module capture_ram_mem
   import capture_ram_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_r [DEPTH];

   // Array write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Registered read sees the pre-write contents on an address collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= {DATA_W{1'b0}};
      end else if (rd_en) begin
         rd_data <= mem_r[rd_addr];
      end
   end

endmodule

// File: rtl/capture_ram.sv
// Triggered circular capture buffer with logical-offset readback.
// Optional macro CAPTURE_RAM_OUTREG_EN adds an output register (read latency 2).
module capture_ram
   import capture_ram_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              in_clk,
   input  logic              in_rst,
   input  logic              in_arm,
   input  logic              in_sample_en,
   input  logic [DATA_W-1:0] in_sample,
   input  logic              in_trig,
   input  logic [ADDR_W-1:0] in_post_cnt,
   input  logic              in_rd_en,
   input  logic [ADDR_W-1:0] in_rd_addr,
   output logic [DATA_W-1:0] out_rd_data,
   output logic              out_rd_valid,
   output logic [1:0]        out_state,
   output logic              out_done,
   output logic              out_wrapped,
   output logic [ADDR_W-1:0] out_trig_addr
);

   localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ONE_A  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] LAST_A = {ADDR_W{1'b1}};

   state_t            state_r;
   logic [ADDR_W-1:0] wptr_r;
   logic [ADDR_W-1:0] post_r;
   logic [ADDR_W-1:0] trig_phys_r;
   logic [ADDR_W-1:0] trig_addr_r;
   logic              wrapped_r;
   logic              done_r;
   logic              rd_valid_r;

   logic              we_s;
   logic [ADDR_W-1:0] wptr_inc_s;
   logic              wrapped_nxt_s;
   logic [ADDR_W-1:0] base_s;
   logic [ADDR_W-1:0] trig_off_s;
   logic [ADDR_W-1:0] rd_phys_s;
   logic [DATA_W-1:0] mem_rdata_s;

   assign we_s          = !in_rst && !in_arm && in_sample_en &&
                          ((state_r == ST_FILL) || (state_r == ST_POST));
   assign wptr_inc_s    = wptr_r + ONE_A;
   assign wrapped_nxt_s = wrapped_r || (wptr_r == LAST_A);
   assign base_s        = wrapped_r ? wptr_r : ZERO_A;
   assign rd_phys_s     = base_s + in_rd_addr;
   // Offset is computed against the post-write pointer so it is already final on entry to DONE.
   assign trig_off_s    = ((state_r == ST_FILL) ? wptr_r : trig_phys_r) -
                          (wrapped_nxt_s ? wptr_inc_s : ZERO_A);

   // Capture control FSM with its registered status outputs.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_r     <= ST_IDLE;
         wptr_r      <= ZERO_A;
         post_r      <= ZERO_A;
         trig_phys_r <= ZERO_A;
         trig_addr_r <= ZERO_A;
         wrapped_r   <= 1'b0;
         done_r      <= 1'b0;
      end else if (in_arm) begin
         state_r     <= ST_FILL;
         wptr_r      <= ZERO_A;
         post_r      <= ZERO_A;
         trig_phys_r <= ZERO_A;
         trig_addr_r <= ZERO_A;
         wrapped_r   <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: state_r <= ST_IDLE;
            ST_FILL: begin
               if (in_sample_en) begin
                  wptr_r    <= wptr_inc_s;
                  wrapped_r <= wrapped_nxt_s;
                  if (in_trig) begin
                     trig_phys_r <= wptr_r;
                     trig_addr_r <= trig_off_s;
                     post_r      <= in_post_cnt;
                     if (in_post_cnt == ZERO_A) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                     end else begin
                        state_r <= ST_POST;
                     end
                  end
               end
            end
            ST_POST: begin
               if (in_sample_en) begin
                  wptr_r      <= wptr_inc_s;
                  wrapped_r   <= wrapped_nxt_s;
                  trig_addr_r <= trig_off_s;
                  post_r      <= post_r - ONE_A;
                  if (post_r == ONE_A) begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                  end
               end
            end
            ST_DONE: state_r <= ST_DONE;
            default: begin
               state_r <= ST_IDLE;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   // Read-valid tracks the request through the memory read register.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         rd_valid_r <= 1'b0;
      end else begin
         rd_valid_r <= in_rd_en;
      end
   end

   capture_ram_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (in_clk),
      .rst     (in_rst),
      .wr_en   (we_s),
      .wr_addr (wptr_r),
      .wr_data (in_sample),
      .rd_en   (in_rd_en),
      .rd_addr (rd_phys_s),
      .rd_data (mem_rdata_s)
   );

`ifdef CAPTURE_RAM_OUTREG_EN
   logic [DATA_W-1:0] rd_data_q_r;
   logic              rd_valid_q_r;

   // Extra output stage for timing closure on the read path.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         rd_data_q_r  <= {DATA_W{1'b0}};
         rd_valid_q_r <= 1'b0;
      end else begin
         rd_data_q_r  <= mem_rdata_s;
         rd_valid_q_r <= rd_valid_r;
      end
   end

   assign out_rd_data  = rd_data_q_r;
   assign out_rd_valid = rd_valid_q_r;
`else
   assign out_rd_data  = mem_rdata_s;
   assign out_rd_valid = rd_valid_r;
`endif

   assign out_state     = state_r;
   assign out_done      = done_r;
   assign out_wrapped   = wrapped_r;
   assign out_trig_addr = trig_addr_r;

endmodule

// File: tb/tb_capture_ram.sv
// Directed bench for capture_ram: a 1024-deep and a 16-deep instance share stimulus.
module tb_capture_ram;

`ifdef CAPTURE_RAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst, arm, sample_en, trig, rd_en;
   logic [15:0] sample;
   logic [9:0]  post_cnt, rd_addr;

   logic [15:0] b_data, s_data;
   logic        b_valid, s_valid, b_done, s_done, b_wrap, s_wrap;
   logic [1:0]  b_state, s_state;
   logic [9:0]  b_taddr;
   logic [3:0]  s_taddr;

   int total = 0;
   int bad   = 0;
   logic [15:0] q_big[$];
   logic [15:0] q_small[$];

   always #5 clk = ~clk;

   capture_ram #(.DATA_W(16), .ADDR_W(10)) u_big (
      .in_clk(clk), .in_rst(rst), .in_arm(arm), .in_sample_en(sample_en),
      .in_sample(sample), .in_trig(trig), .in_post_cnt(post_cnt),
      .in_rd_en(rd_en), .in_rd_addr(rd_addr), .out_rd_data(b_data),
      .out_rd_valid(b_valid), .out_state(b_state), .out_done(b_done),
      .out_wrapped(b_wrap), .out_trig_addr(b_taddr)
   );

   capture_ram #(.DATA_W(16), .ADDR_W(4)) u_small (
      .in_clk(clk), .in_rst(rst), .in_arm(arm), .in_sample_en(sample_en),
      .in_sample(sample), .in_trig(trig), .in_post_cnt(post_cnt[3:0]),
      .in_rd_en(rd_en), .in_rd_addr(rd_addr[3:0]), .out_rd_data(s_data),
      .out_rd_valid(s_valid), .out_state(s_state), .out_done(s_done),
      .out_wrapped(s_wrap), .out_trig_addr(s_taddr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_sample(input logic [15:0] val, input logic t);
      sample_en = 1'b1;
      sample    = val;
      trig      = t;
      tick();
      sample_en = 1'b0;
      trig      = 1'b0;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic do_read(input logic [9:0] addr, input logic [15:0] exp_big,
                          input logic [15:0] exp_small);
      int n;
      rd_addr = addr;
      rd_en   = 1'b1;
      q_big.push_back(exp_big);
      q_small.push_back(exp_small);
      tick();
      rd_en = 1'b0;
      n = 1;
      while (!b_valid && n < 6) begin
         tick();
         n++;
      end
      chk("rd_latency", n, LAT);
      chk("rd_valid_small", {31'd0, s_valid}, 32'd1);
      chk("rd_data_big", {16'd0, b_data}, {16'd0, q_big.pop_front()});
      chk("rd_data_small", {16'd0, s_data}, {16'd0, q_small.pop_front()});
   endtask

   initial begin
      rst = 1'b1; arm = 1'b0; sample_en = 1'b0; trig = 1'b0; rd_en = 1'b0;
      sample = 16'd0; post_cnt = 10'd0; rd_addr = 10'd0;
      tick();
      tick();
      chk("rst_state_big", {30'd0, b_state}, 32'd0);
      chk("rst_state_small", {30'd0, s_state}, 32'd0);
      chk("rst_done", {31'd0, b_done | s_done}, 32'd0);
      chk("rst_wrap", {31'd0, b_wrap | s_wrap}, 32'd0);
      chk("rst_valid", {31'd0, b_valid | s_valid}, 32'd0);
      chk("rst_data", {b_data, s_data}, 32'd0);
      chk("rst_taddr", {18'd0, b_taddr, s_taddr}, 32'd0);
      rst = 1'b0;
      tick();
      chk("idle_hold", {30'd0, b_state}, 32'd0);

      // Basic capture: trigger on sample 5, three post samples.
      post_cnt = 10'd3;
      do_arm();
      chk("arm_fill", {30'd0, b_state}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         drive_sample(16'(i), i == 5);
         if (i == 7) chk("t1_post", {30'd0, b_state}, 32'd2);
         if (i == 8) begin
            chk("t1_done_state", {30'd0, b_state}, 32'd3);
            chk("t1_done", {31'd0, b_done}, 32'd1);
         end
      end
      chk("t1_wrap", {31'd0, b_wrap}, 32'd0);
      chk("t1_taddr_big", {22'd0, b_taddr}, 32'd5);
      chk("t1_taddr_small", {28'd0, s_taddr}, 32'd5);
      do_read(10'd5, 16'd5, 16'd5);

      // Wrap case on the 16-deep instance.
      post_cnt = 10'd2;
      do_arm();
      for (int i = 0; i < 20; i++) drive_sample(16'(i), i == 17);
      chk("t2_state_small", {30'd0, s_state}, 32'd3);
      chk("t2_wrap_small", {31'd0, s_wrap}, 32'd1);
      chk("t2_taddr_small", {28'd0, s_taddr}, 32'd13);
      chk("t2_wrap_big", {31'd0, b_wrap}, 32'd0);
      chk("t2_taddr_big", {22'd0, b_taddr}, 32'd17);
      do_read(10'd0, 16'd0, 16'd4);
      do_read(10'd15, 16'd15, 16'd19);

      // Zero post count: trigger on the first sample completes immediately.
      post_cnt = 10'd0;
      do_arm();
      drive_sample(16'h00A0, 1'b1);
      chk("t3_done_state", {30'd0, s_state}, 32'd3);
      chk("t3_done", {31'd0, b_done}, 32'd1);
      chk("t3_taddr", {18'd0, b_taddr, s_taddr}, 32'd0);
      sample_en = 1'b1;
      sample    = 16'h00BB;
      tick(); tick(); tick();
      sample_en = 1'b0;
      chk("t3_stay_done", {30'd0, b_state}, 32'd3);
      do_read(10'd0, 16'h00A0, 16'h00A0);
      do_read(10'd1, 16'd1, 16'd17);

      // Arm during POST aborts; that cycle's sample is dropped.
      post_cnt = 10'd5;
      do_arm();
      drive_sample(16'h0100, 1'b0);
      drive_sample(16'h0101, 1'b0);
      drive_sample(16'h0102, 1'b1);
      chk("t4_post", {30'd0, b_state}, 32'd2);
      arm = 1'b1; sample_en = 1'b1; sample = 16'hDEAD; trig = 1'b1;
      tick();
      arm = 1'b0; sample_en = 1'b0; trig = 1'b0;
      chk("t4_abort_state", {30'd0, s_state}, 32'd1);
      chk("t4_abort_wrap", {31'd0, b_wrap | s_wrap}, 32'd0);
      post_cnt = 10'd0;
      drive_sample(16'h0C00, 1'b1);
      chk("t4_rearm_done", {30'd0, b_state}, 32'd3);
      chk("t4_wptr_zero", {22'd0, b_taddr}, 32'd0);
      do_read(10'd3, 16'd3, 16'd19);
      do_read(10'd0, 16'h0C00, 16'h0C00);

      // Reset in POST overrides arm/sample/trig; memory is kept.
      post_cnt = 10'd10;
      do_arm();
      for (int i = 0; i < 4; i++) drive_sample(16'h0200 + 16'(i), i == 1);
      chk("t5_post", {30'd0, b_state}, 32'd2);
      rst = 1'b1; arm = 1'b1; sample_en = 1'b1; sample = 16'h0BAD; trig = 1'b1;
      tick();
      chk("t5_rst_state", {28'd0, b_state, s_state}, 32'd0);
      chk("t5_rst_done", {31'd0, b_done | s_done}, 32'd0);
      chk("t5_rst_wrap", {31'd0, b_wrap | s_wrap}, 32'd0);
      chk("t5_rst_valid", {31'd0, b_valid | s_valid}, 32'd0);
      chk("t5_rst_data", {b_data, s_data}, 32'd0);
      chk("t5_rst_taddr", {18'd0, b_taddr, s_taddr}, 32'd0);
      rst = 1'b0; arm = 1'b0; sample_en = 1'b0; trig = 1'b0;
      do_arm();
      chk("t5_rearm", {30'd0, b_state}, 32'd1);
      for (int i = 0; i < 4; i++)
         do_read(10'(i), 16'h0200 + 16'(i), 16'h0200 + 16'(i));
      do_read(10'd4, 16'd4, 16'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/capture_ram.md
CAPTURE_RAM -- requirements
Module: capture_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width in bits.
REQ-002 SHALL have parameter ADDR_W, default 10, address width; depth = 2**ADDR_W (1024).
REQ-003 SHALL have port in_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port in_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_arm  input  1  single-cycle pulse; starts a new capture.
REQ-006 SHALL have port in_sample_en  input  1  sample strobe; a sample is written only in a cycle where this is 1.
REQ-007 SHALL have port in_sample  input  DATA_W  sample data.
REQ-008 SHALL have port in_trig  input  1  trigger; qualified only with in_sample_en=1.
REQ-009 SHALL have port in_post_cnt  input  ADDR_W  samples to write after the trigger sample; sampled at trigger.
REQ-010 SHALL have port in_rd_en  input  1  read request.
REQ-011 SHALL have port in_rd_addr  input  ADDR_W  logical read offset; 0 = oldest stored sample.
REQ-012 SHALL have port out_rd_data  output  DATA_W  read data.
REQ-013 SHALL have port out_rd_valid  output  1  out_rd_data valid this cycle.
REQ-014 SHALL have port out_state  output  2  FSM state: 0 IDLE, 1 FILL, 2 POST, 3 DONE.
REQ-015 SHALL have port out_done  output  1  high while in DONE.
REQ-016 SHALL have port out_wrapped  output  1  write pointer has wrapped at least once since arm.
REQ-017 SHALL have port out_trig_addr  output  ADDR_W  logical offset of the trigger sample, valid in DONE.

Function
REQ-018 SHALL idle in IDLE with no writes; in_arm moves to FILL, clears wptr and out_wrapped.
REQ-019 SHALL write in_sample at wptr in FILL and POST when in_sample_en=1, then wptr += 1 modulo depth; wrap 2**ADDR_W-1 -> 0 sets out_wrapped.
REQ-020 SHALL in FILL, on in_sample_en=1 and in_trig=1, write that sample, record its physical address, load post counter with in_post_cnt, and enter POST; if in_post_cnt=0, enter DONE instead.
REQ-021 SHALL in POST decrement the post counter per written sample and enter DONE on the write that takes it to 0; in_trig ignored in POST.
REQ-022 SHALL perform no writes in DONE; out_done=1; in_arm restarts at FILL.
REQ-023 SHALL treat in_arm in FILL or POST as abort-and-restart: next state FILL, wptr=0, out_wrapped=0, the same-cycle sample not written.
REQ-024 SHALL give in_arm priority over in_trig in the same cycle.
REQ-025 SHALL map logical read offset to physical address = (out_wrapped ? wptr : 0) + in_rd_addr, modulo depth.
REQ-026 SHALL report out_trig_addr = trigger physical address minus (out_wrapped ? wptr : 0), modulo depth.
REQ-027 SHALL accept reads in every state; read latency 1 cycle (see REQ-031); out_rd_valid mirrors in_rd_en delayed by the latency.
REQ-028 SHALL return old data (read-first) on same-cycle read/write to the same physical address.

Reset
REQ-029 SHALL on in_rst=1 set state IDLE, wptr 0, post counter 0, out_wrapped 0, out_done 0, out_rd_valid 0, out_rd_data 0, out_trig_addr 0.
REQ-030 SHALL NOT clear memory contents on reset; in_rst mid-capture aborts it, and in_rst overrides all other inputs.

Configuration
REQ-031 SHALL support macro CAPTURE_RAM_OUTREG_EN: defined -> extra output register, read latency 2 cycles, out_rd_valid delayed 2; undefined -> latency 1.

Structure
REQ-032 SHALL place FSM state encodings and default parameter values in package capture_ram_pkg.
REQ-033 SHALL instantiate one sub-module capture_ram_mem: simple dual-port DATA_W x 2**ADDR_W array, one write port, one registered read port, read-first.

Verification
REQ-034 SHALL cover: arm, 10 samples 0..9, trig on sample 5, in_post_cnt=3 -> DONE after sample 8, out_wrapped=0, out_trig_addr=5, read offset 5 returns 5 after 1 cycle.
REQ-035 SHALL cover: ADDR_W=4, arm, 20 samples 0..19, trig on sample 17, post 2 -> out_wrapped=1, offset 0 reads 4, out_trig_addr=13.
REQ-036 SHALL cover: in_post_cnt=0, trig on first sample -> DONE next cycle, out_trig_addr=0, no further writes while in_sample_en held.
REQ-037 SHALL cover: in_arm during POST -> out_state=1 next cycle, wptr 0, sample that cycle not written.
REQ-038 SHALL cover: in_rst asserted in POST -> all outputs at reset values next cycle; memory retains prior data, verified by reading after a re-arm.
REQ-039 SHALL cover: same stimulus with and without CAPTURE_RAM_OUTREG_EN -> out_rd_valid at +2 and +1 cycles after in_rd_en.
